// File: rtl/draw_sequencer_if.sv
// Bundle of the sequencer's stage handshakes, source pixel streams and adapter-side outputs.
interface draw_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             go;
  logic             fill_start;
  logic             fill_done;
  logic [7:0]       fill_x;
  logic [6:0]       fill_y;
  logic [2:0]       fill_col;
  logic             fill_plot;
  logic             shp_start;
  logic             shp_done;
  logic [7:0]       shp_x;
  logic [6:0]       shp_y;
  logic [2:0]       shp_col;
  logic             shp_plot;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] clip_count;

  modport master (
    input  go, fill_done, fill_x, fill_y, fill_col, fill_plot,
           shp_done, shp_x, shp_y, shp_col, shp_plot,
    output fill_start, shp_start, vga_x, vga_y, vga_colour, vga_plot,
           busy, done, err, clip_count
  );

  modport slave (
    output go, fill_done, fill_x, fill_y, fill_col, fill_plot,
           shp_done, shp_x, shp_y, shp_col, shp_plot,
    input  fill_start, shp_start, vga_x, vga_y, vga_colour, vga_plot,
           busy, done, err, clip_count
  );
endinterface

// File: rtl/draw_sequencer.sv
// Frame controller: runs the fill stage then the shape stage, muxes their pixels to the
// VGA adapter with clipping, and aborts a stage that never signals done.
module draw_sequencer #(
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120,
  parameter int TIMEOUT = 32768,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  draw_sequencer_if.master bus
);
  localparam int                WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [8:0]        X_LIM   = 9'(SCR_W);
  localparam logic [7:0]        Y_LIM   = 8'(SCR_H);

  typedef enum logic [2:0] {
    IDLE, F_RUN, F_REL, S_RUN, S_REL, DONE, ERR
  } state_t;

  state_t           state_q;
  logic             fill_start_q, shp_start_q, busy_q, done_q, err_q;
  logic [WD_W-1:0]  wdog_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_start_q <= 1'b0;
      shp_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.go) begin
          state_q      <= F_RUN;
          fill_start_q <= 1'b1;
          busy_q       <= 1'b1;
          wdog_q       <= '0;
        end
        F_RUN: if (bus.fill_done) begin
          state_q      <= F_REL;
          fill_start_q <= 1'b0;
        end else if (wdog_q == WD_LAST) begin
          state_q      <= ERR;
          fill_start_q <= 1'b0;
          busy_q       <= 1'b0;
          err_q        <= 1'b1;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
        F_REL: if (!bus.fill_done) begin
          state_q     <= S_RUN;
          shp_start_q <= 1'b1;
          wdog_q      <= '0;
        end
        S_RUN: if (bus.shp_done) begin
          state_q     <= S_REL;
          shp_start_q <= 1'b0;
        end else if (wdog_q == WD_LAST) begin
          state_q     <= ERR;
          shp_start_q <= 1'b0;
          busy_q      <= 1'b0;
          err_q       <= 1'b1;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
        S_REL: if (!bus.shp_done) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        ERR: state_q <= ERR;
        default: begin
          state_q      <= IDLE;
          fill_start_q <= 1'b0;
          shp_start_q  <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  // Only the stage owning the current state may drive pixels; the other is ignored.
  logic       src_plot;
  logic [7:0] src_x;
  logic [6:0] src_y;
  logic [2:0] src_col;
  logic       in_range;

  always_comb begin
    src_plot = 1'b0;
    src_x    = '0;
    src_y    = '0;
    src_col  = '0;
    case (state_q)
      F_RUN, F_REL: begin
        src_plot = bus.fill_plot;
        src_x    = bus.fill_x;
        src_y    = bus.fill_y;
        src_col  = bus.fill_col;
      end
      S_RUN, S_REL: begin
        src_plot = bus.shp_plot;
        src_x    = bus.shp_x;
        src_y    = bus.shp_y;
        src_col  = bus.shp_col;
      end
      default: ;
    endcase
    in_range = ({1'b0, src_x} < X_LIM) && ({1'b0, src_y} < Y_LIM);
  end

  logic [7:0]       vga_x_q;
  logic [6:0]       vga_y_q;
  logic [2:0]       vga_col_q;
  logic             vga_plot_q;
  logic [CNT_W-1:0] clip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_col_q  <= '0;
      vga_plot_q <= 1'b0;
      clip_q     <= '0;
    end else begin
      vga_plot_q <= src_plot && in_range;
      if (src_plot && in_range) begin
        vga_x_q   <= src_x;
        vga_y_q   <= src_y;
        vga_col_q <= src_col;
      end
      // Frame start clears the clip tally; otherwise count clipped pixels, saturating.
      if (state_q == IDLE && bus.go)
        clip_q <= '0;
      else if (src_plot && !in_range && clip_q != '1)
        clip_q <= clip_q + 1'b1;
    end
  end

  assign bus.fill_start = fill_start_q;
  assign bus.shp_start  = shp_start_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_col_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.clip_count = clip_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: expected pixels are queued when driven and popped
// as the adapter-side strobe appears; a second instance with a short watchdog covers ERR.
module tb_draw_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  draw_sequencer_if #(.CNT_W(16)) bus ();
  draw_sequencer_if #(.CNT_W(16)) bus2 ();

  draw_sequencer #(.SCR_W(160), .SCR_H(120), .TIMEOUT(32768), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  draw_sequencer #(.SCR_W(160), .SCR_H(120), .TIMEOUT(64), .CNT_W(16)) dut_wd (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   plot_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and reconcile the adapter strobe with the scoreboard.
  task automatic cyc();
    pix_t e;
    @(negedge clk);
    if (bus.vga_plot === 1'b1) plot_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("vga_plot", 32'(bus.vga_plot), 32'd1);
      check("vga_pix", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(e));
    end else if (bus.vga_plot !== 1'b0) begin
      check("stray_plot", 32'(bus.vga_plot), 32'd0);
    end
  endtask

  task automatic fill_pix(input int x, input int y, input int c, input bit expect_out);
    pix_t p;
    bus.fill_x = 8'(x); bus.fill_y = 7'(y); bus.fill_col = 3'(c); bus.fill_plot = 1'b1;
    p.x = 8'(x); p.y = 7'(y); p.c = 3'(c);
    if (expect_out) sb.push_back(p);
  endtask

  task automatic shp_pix(input int x, input int y, input int c, input bit expect_out);
    pix_t p;
    bus.shp_x = 8'(x); bus.shp_y = 7'(y); bus.shp_col = 3'(c); bus.shp_plot = 1'b1;
    p.x = 8'(x); p.y = 7'(y); p.c = 3'(c);
    if (expect_out) sb.push_back(p);
  endtask

  initial begin
    bus.go = 0; bus.fill_done = 0; bus.fill_x = 0; bus.fill_y = 0; bus.fill_col = 0; bus.fill_plot = 0;
    bus.shp_done = 0; bus.shp_x = 0; bus.shp_y = 0; bus.shp_col = 0; bus.shp_plot = 0;
    bus2.go = 0; bus2.fill_done = 0; bus2.fill_x = 0; bus2.fill_y = 0; bus2.fill_col = 0; bus2.fill_plot = 0;
    bus2.shp_done = 0; bus2.shp_x = 0; bus2.shp_y = 0; bus2.shp_col = 0; bus2.shp_plot = 0;

    // Reset state
    cyc(); cyc();
    check("rst_outputs", 32'({bus.fill_start, bus.shp_start, bus.vga_plot, bus.busy, bus.done, bus.err}), 32'd0);
    check("rst_clip", 32'(bus.clip_count), 32'd0);
    check("rst_vga_xy", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Full-screen fill; done arrives together with the last pixel
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    check("fill_start_rise", 32'(bus.fill_start), 32'd1);
    check("busy_run", 32'(bus.busy), 32'd1);
    plot_cnt = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        fill_pix(x, y, x + y, 1'b1);
        if (x == 159 && y == 119) bus.fill_done = 1'b1;
        cyc();
      end
    end
    bus.fill_plot = 1'b0;
    check("fill_start_fall", 32'(bus.fill_start), 32'd0);
    check("fill_plot_count", 32'(plot_cnt), 32'd19200);
    check("last_pix", 32'({bus.vga_x, bus.vga_y}), 32'({8'd159, 7'd119}));

    // Fill stage keeps done high for 3 cycles; shape must wait
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("shp_start_wait", 32'(bus.shp_start), 32'd0);
    end
    bus.fill_done = 1'b0;
    cyc();
    check("shp_start_rise", 32'(bus.shp_start), 32'd1);

    // Clipping in the shape stage
    shp_pix(160, 5, 1, 1'b0);
    cyc();
    check("clip_x_hold", 32'({bus.vga_x, bus.vga_y}), 32'({8'd159, 7'd119}));
    check("clip_cnt1", 32'(bus.clip_count), 32'd1);
    shp_pix(3, 120, 2, 1'b0);
    cyc();
    check("clip_y_hold", 32'({bus.vga_x, bus.vga_y}), 32'({8'd159, 7'd119}));
    shp_pix(10, 10, 5, 1'b1);
    cyc();
    bus.shp_plot = 1'b0;
    check("clip_cnt2", 32'(bus.clip_count), 32'd2);

    // Shape handshake and the one-cycle done pulse
    bus.shp_done = 1'b1;
    cyc();
    check("shp_start_fall", 32'(bus.shp_start), 32'd0);
    cyc();
    check("done_low_rel", 32'(bus.done), 32'd0);
    bus.shp_done = 1'b0;
    cyc();
    check("done_pulse", 32'({bus.done, bus.busy}), 32'b10);
    cyc();
    check("done_end", 32'(bus.done), 32'd0);
    check("frame_hold", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'({8'd10, 7'd10, 3'd5}));

    // Second frame: clip tally cleared, stray shape plots ignored during fill
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    check("f2_start", 32'(bus.fill_start), 32'd1);
    check("f2_clip_clr", 32'(bus.clip_count), 32'd0);
    shp_pix(20, 20, 4, 1'b0);
    cyc();
    fill_pix(1, 2, 3, 1'b1);
    shp_pix(50, 50, 7, 1'b0);
    cyc();
    bus.shp_plot = 1'b0;
    check("both_fill_wins", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'({8'd1, 7'd2, 3'd3}));
    for (int i = 0; i < 500; i++) begin
      fill_pix(i % 160, i / 160, i, 1'b1);
      cyc();
    end
    bus.fill_plot = 1'b0;

    // Asynchronous reset mid-fill
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 32'({bus.fill_start, bus.shp_start, bus.vga_plot, bus.busy, bus.done, bus.err}), 32'd0);
    check("mid_rst_pix", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    sb.delete();
    cyc(); cyc();
    rst_n = 1'b1;
    fill_pix(5, 5, 1, 1'b0);
    cyc(); cyc();
    check("no_pix_before_go", 32'({bus.vga_plot, bus.busy}), 32'd0);
    bus.fill_plot = 1'b0;
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    check("restart_fill", 32'(bus.fill_start), 32'd1);
    check("restart_clip", 32'(bus.clip_count), 32'd0);
    fill_pix(200, 0, 1, 1'b0);
    cyc();
    bus.fill_plot = 1'b0;
    check("restart_clip1", 32'(bus.clip_count), 32'd1);

    // Watchdog on the short-timeout instance
    rst2_n = 1'b1;
    cyc();
    bus2.go = 1'b1;
    cyc();
    bus2.go = 1'b0;
    bus2.fill_done = 1'b1;
    cyc();
    bus2.fill_done = 1'b0;
    cyc();
    check("wd_shp_start", 32'(bus2.shp_start), 32'd1);
    bus2.shp_x = 8'd1; bus2.shp_y = 7'd1; bus2.shp_col = 3'd6; bus2.shp_plot = 1'b1;
    for (int i = 0; i < 63; i++) cyc();
    check("wd_not_yet", 32'({bus2.err, bus2.shp_start, bus2.vga_plot}), 32'b011);
    cyc();
    check("wd_err", 32'({bus2.err, bus2.shp_start, bus2.busy}), 32'b100);
    cyc();
    check("wd_plot_off", 32'(bus2.vga_plot), 32'd0);
    bus2.go = 1'b1;
    cyc(); cyc(); cyc();
    check("wd_go_ignored", 32'({bus2.err, bus2.fill_start, bus2.busy, bus2.done}), 32'b1000);
    bus2.go = 1'b0;
    bus2.shp_plot = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
